// File: rtl/instr_encoder_loader.sv
// Encodes symbolic KGP-RISC instructions and writes them sequentially into instruction memory.
// One word per two cycles; in_ready drops while the registered word is being written.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [25:0]       imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

  state_t      state;
  logic        last_q;
  logic [5:0]  opcode;
  logic [31:0] enc_word;
  logic [1:0]  enc_code;

  // Encoder: enc_code is nonzero when the request cannot be encoded.
  always_comb begin
    enc_word = '0;
    enc_code = 2'd0;
    opcode   = 6'd0;
    if (op_sel >= 5'd28) begin
      enc_code = 2'd1;
    end else if (op_sel <= 5'd11) begin
      enc_word = {6'd0, rs, rt, 5'd0, 6'd0, op_sel};
      if (op_sel == 5'd4 || op_sel == 5'd5 || op_sel == 5'd8)
        enc_word[15:11] = imm[4:0];
    end else begin
      opcode = {1'b0, op_sel} - 6'd11;
      case (opcode)
        6'd1, 6'd2, 6'd15, 6'd16: begin
          enc_word = {opcode, rs, rt, imm[15:0]};
          if (!((&imm[25:15]) || !(|imm[25:15])))
            enc_code = 2'd2;
        end
        6'd4, 6'd14: enc_word = {opcode, rs, 21'd0};
        default:     enc_word = {opcode, imm};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      word_count <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LOAD;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            mem_addr   <= BASE;
            word_count <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (enc_code != 2'd0) begin
              state    <= S_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= enc_code;
            end else begin
              state     <= S_WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= enc_word;
              last_q    <= in_last;
            end
          end
        end
        S_WRITE: begin
          mem_we     <= 1'b0;
          word_count <= word_count + 1'b1;
          // The address saturates at the top of memory rather than wrapping.
          if (mem_addr != LAST_ADDR)
            mem_addr <= mem_addr + 1'b1;
          if (last_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (mem_addr == LAST_ADDR) begin
            state    <= S_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'd3;
          end else begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed and random sessions against a behavioural encoder/loader model.
module tb_instr_encoder_loader;

  localparam int AW   = 2;
  localparam int BASE = 0;
  localparam int CAP  = 1 << AW;

  typedef struct {
    int          op;
    int          rs;
    int          rt;
    logic [25:0] imm;
    bit          last;
  } req_t;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, in_last;
  logic [4:0]    op_sel, rs, rt;
  logic [25:0]   imm;
  logic          mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  int n_checks = 0;
  int n_pass   = 0;
  int          got_addr[$];
  logic [31:0] got_data[$];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .imm(imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .word_count(word_count)
  );

  always @(negedge clk)
    if (mem_we) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(mem_wdata);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference encoder straight from the instruction-format rules.
  function automatic void ref_encode(input req_t r, output logic [31:0] w, output int code);
    int opc, simm, sh;
    w = '0;
    code = 0;
    if (r.op >= 28) begin
      code = 1;
    end else if (r.op <= 11) begin
      sh = (r.op == 4 || r.op == 5 || r.op == 8) ? int'(r.imm[4:0]) : 0;
      w = 32'(r.rs * (1 << 21) + r.rt * (1 << 16) + sh * (1 << 11) + r.op);
    end else begin
      opc = r.op - 11;
      if (opc == 1 || opc == 2 || opc == 15 || opc == 16) begin
        simm = int'(r.imm);
        if (simm >= (1 << 25)) simm -= (1 << 26);
        if (simm < -32768 || simm > 32767) code = 2;
        else w = 32'(opc * (1 << 26) + r.rs * (1 << 21) + r.rt * (1 << 16) + (simm & 'hFFFF));
      end else if (opc == 4 || opc == 14) begin
        w = 32'(opc * (1 << 26) + r.rs * (1 << 21));
      end else begin
        w = 32'(opc * (1 << 26) + int'(r.imm));
      end
    end
  endfunction

  function automatic req_t mk(input int op, input int rs_v, input int rt_v, input logic [25:0] im, input bit lst);
    req_t r;
    r.op = op; r.rs = rs_v; r.rt = rt_v; r.imm = im; r.last = lst;
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Holds the request on the inputs until it is accepted; returns #1 after the accepting edge.
  task automatic send(input req_t r, output time hs_time);
    bit ok = 0;
    op_sel = 5'(r.op); rs = 5'(r.rs); rt = 5'(r.rt); imm = r.imm; in_last = r.last;
    in_valid = 1'b1;
    hs_time = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        hs_time = $time;
        #1;
        ok = 1;
        break;
      end
    end
    if (!ok) chk("handshake_timeout", 0, 1);
  endtask

  task automatic run_session(input req_t reqs[$], input string tag);
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] w;
    int          addr, cnt, code, exp_code, n_send;
    bit          exp_done;
    time         t;
    addr = BASE; cnt = 0; exp_code = 0; exp_done = 0; n_send = reqs.size();
    for (int i = 0; i < reqs.size(); i++) begin
      ref_encode(reqs[i], w, code);
      if (code != 0) begin exp_code = code; n_send = i + 1; break; end
      exp_addr.push_back(addr);
      exp_data.push_back(w);
      cnt++;
      if (reqs[i].last) begin exp_done = 1; n_send = i + 1; break; end
      if (addr == CAP - 1) begin exp_code = 3; n_send = i + 1; break; end
      addr++;
    end
    got_addr.delete();
    got_data.delete();
    do_start();
    chk({tag, "_start_err"}, err, 0);
    chk({tag, "_start_busy"}, busy, 1);
    for (int i = 0; i < n_send; i++) send(reqs[i], t);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk({tag, "_addr"}, got_addr[i], exp_addr[i]);
      chk({tag, "_wdata"}, got_data[i], exp_data[i]);
    end
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_code != 0);
    chk({tag, "_err_code"}, err_code, exp_code);
    chk({tag, "_word_count"}, word_count, cnt);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    if (exp_code == 1 || exp_code == 2) chk({tag, "_addr_frozen"}, mem_addr, addr);
    if (exp_done && addr < CAP - 1) chk({tag, "_addr_next"}, mem_addr, addr + 1);
  endtask

  initial begin
    req_t q[$];
    time  t1, t2;
    int   n;
    logic [25:0] r26;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    op_sel = '0; rs = '0; rt = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    q = '{mk(0, 3, 5, 26'd0, 1)};
    run_session(q, "add");

    q = '{mk(4, 2, 0, 26'd7, 0), mk(12, 2, 1, 26'h3FFFFFC, 1)};
    run_session(q, "sll_lw");

    // Back-to-back: in_valid stays high across both requests.
    got_addr.delete(); got_data.delete();
    do_start();
    send(mk(14, 0, 0, 26'h123, 0), t1);
    send(mk(25, 31, 0, 26'd0, 1), t2);
    in_valid = 1'b0;
    chk("b2b_gap", 32'(t2 - t1), 32'd20);
    repeat (3) @(negedge clk);
    chk("b2b_nwrites", got_addr.size(), 2);
    if (got_data.size() == 2) begin
      chk("b2b_br", got_data[0], 32'h0C000123);
      chk("b2b_ret", got_data[1], 32'h3BE00000);
      chk("b2b_addr1", got_addr[1], 1);
    end
    chk("b2b_done", done, 1);

    q = '{mk(26, 0, 0, 26'h8000, 1)};
    run_session(q, "imm_range");
    q = '{mk(30, 0, 0, 26'd0, 1)};
    run_session(q, "illegal_op");
    q = '{mk(0, 1, 1, 26'd0, 0), mk(1, 2, 2, 26'd0, 0), mk(2, 3, 3, 26'd0, 0),
          mk(3, 4, 4, 26'd0, 0), mk(0, 5, 5, 26'd0, 1)};
    run_session(q, "overflow");

    // Reset while the write strobe is up.
    do_start();
    send(mk(0, 1, 2, 26'd0, 0), t1);
    chk("rst_pre_we", mem_we, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst_mid");
    @(negedge clk);
    chk("rst_mid_we_low", mem_we, 0);
    q = '{mk(0, 7, 8, 26'd0, 1)};
    run_session(q, "after_rst");

    for (int s = 0; s < 20; s++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        r26 = 26'($urandom);
        if ($urandom_range(0, 1) == 1) r26 = {{10{r26[15]}}, r26[15:0]};
        q.push_back(mk(($urandom_range(0, 9) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(0, 27)),
                       $urandom_range(0, 31), $urandom_range(0, 31), r26, i == n - 1));
      end
      run_session(q, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the KGP-RISC control-unit decode path. Accepts one symbolic instruction per handshake (mnemonic select, register fields, immediate) and encodes it into a 32-bit KGP-RISC instruction word.
- Writes each encoded word sequentially into instruction memory through a single-port write interface.
- Used as the boot or program loader ahead of the single-cycle core, and as a stimulus generator for core benches.

Parameters:
- ADDR_W, 10, instruction-memory word-address width. Capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after each start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. Begins a load session. Honoured only in IDLE, DONE or ERR.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- op_sel  in  5  mnemonic select. 0–11: R-type with opcode 0 and opcode_ext = op_sel. 12–27: opcode = op_sel − 11 (1..16). 28–31: illegal.
- rs  in  5  first register field.
- rt  in  5  second register field.
- imm  in  26  immediate, branch target or shift amount (imm[4:0]).
- in_last  in  1  marks the final instruction of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  program written successfully. Held until next start or rst.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 illegal op_sel, 2 immediate out of range, 3 memory overflow.
- word_count  out  ADDR_W+1  words written in the current session.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - busy=0, done=0, err=0, err_code=0, word_count=0.
  - rst wins over every other input, including mid-session. mem_we is low the cycle after rst.
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Go to LOAD.
  - mem_addr=BASE_ADDR, word_count=0.
  - Clear done, err, err_code.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, register the encoded word and the last flag, then go to WRITE.
  - If the request is illegal, go to ERR instead. Set err_code and write nothing.
  - start is ignored.
- WRITE:
  - mem_we=1 for exactly one cycle with the current mem_addr and mem_wdata. in_ready=0.
  - Next edge: mem_addr++ and word_count++.
  - If last is set, go to DONE.
  - Else if the written address was 2^ADDR_W−1, go to ERR with code 3. No wrap.
  - Else go to LOAD.
- Throughput and latency:
  - One word per 2 cycles.
  - Handshake at edge N gives mem_we high during cycle N+1.
- Encoding, in bit order [31:26 | 25:21 | 20:16 | 15:11 | 10:0]:
  - R-type, op_sel 0–11: {6'd0, rs, rt, shamt, op_sel[10:0] zero-extended}. shamt=imm[4:0] for ext 4, 5, 8 (constant shifts), otherwise 0.
  - Memory/ALU-immediate, opcodes 1, 2, 15, 16: {opcode, rs, rt, imm[15:0]}.
    - imm must fit signed 16 bits, i.e. imm[25:15] all equal. Otherwise code 2.
  - Branch/call, opcodes 3, 5–13: {opcode, imm[25:0]}.
  - Register branch/return, opcodes 4, 14: {opcode, rs, 21'd0}.
  - op_sel 28–31: code 1.
- ERR:
  - err=1, busy=0, in_ready=0.
  - mem_addr and word_count frozen.
  - Leaves only on start or rst.
- DONE: done=1, busy=0, in_ready=0, counters frozen.
- in_valid while in_ready=0 is held off. Requests are never dropped or duplicated.

Test Plan:
- Add r3,r5: op_sel=0, rs=3, rt=5, in_last=1 → one mem_we pulse, addr=0, wdata=0x00650000. done=1, word_count=1.
- Constant shift: op_sel=4, rs=2, rt=0, imm=7 → wdata=0x00403804. Then lw: op_sel=12, rs=2, rt=1, imm=26'h3FFFFFC → wdata=0x0441FFFC at addr 1.
- br: op_sel=14, imm=0x123 → wdata=0x0C000123. Then ret: op_sel=25, rs=31 → wdata=0x3BE00000. Expect back-to-back in_valid held high, in_ready toggling every other cycle, no lost word.
- Immediate out of range: addi op_sel=26, imm=0x8000 → no mem_we, err=1, err_code=2, in_ready=0. Then start → err cleared, LOAD. op_sel=30 → err_code=1.
- Overflow: ADDR_W=2, four non-last requests → writes to addr 0..3, then err_code=3, word_count=4, no fifth write.
- Reset mid-session: rst asserted during WRITE → mem_we low next cycle, all outputs at reset values. Following start restarts at BASE_ADDR.
